// File: rtl/auto_off_ctrl.sv
// auto_off_ctrl: auto power-off controller for the washer control path.
// Keeps the machine powered once the power switch releases reset, then shuts it down
// after a programme finish or an idle period, always through a warning phase, and
// records why it switched off. A power key edge wakes the machine from OFF.
//
// Ports:
//   clk_s          system clock
//   reset          async active-low reset (power switch, low = off)
//   tick_en        one-cycle time-base strobe; all timing advances only on it
//   finish         programme-finished level (rising edge is the event)
//   running        programme running; holds the idle timer at zero
//   activity       user activity levels (rising edge on any bit is the event)
//   power_key      wake request from OFF (rising edge is the event)
//   power_on       registered machine power enable
//   power_led      reset & power_on
//   warn_led       blinks during the warning phase
//   finish_pending finish seen, shut-down pending
//   remain         ticks left in FIN_WAIT/WARN countdown, 0 elsewhere
//   off_cause      0 none, 1 finish timeout, 2 idle timeout
module auto_off_ctrl #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned FINISH_TIMEOUT = 10,
  parameter int unsigned IDLE_TIMEOUT   = 60,
  parameter int unsigned WARN_TICKS     = 3,
  parameter int unsigned N_ACT          = 3
) (
  input  logic             clk_s,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             finish,
  input  logic             running,
  input  logic [N_ACT-1:0] activity,
  input  logic             power_key,
  output logic             power_on,
  output logic             power_led,
  output logic             warn_led,
  output logic             finish_pending,
  output logic [CNT_W-1:0] remain,
  output logic [1:0]       off_cause
);

  localparam logic [CNT_W-1:0] FIN_LD  = CNT_W'(FINISH_TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] WARN_LD = CNT_W'(WARN_TICKS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_FINISH = 2'd1;
  localparam logic [1:0] CAUSE_IDLE   = 2'd2;

  typedef enum logic [2:0] {
    StInit,
    StOn,
    StFinWait,
    StWarn,
    StOff
  } state_e;

  state_e           r_state;
  logic             r_prev_finish;
  logic [N_ACT-1:0] r_prev_act;
  logic             r_prev_key;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] r_remain;
  logic [1:0]       r_cause;
  logic [1:0]       r_off_cause;
  logic             r_power_on;
  logic             r_warn_led;
  logic             r_finish_pending;

  logic w_fin_edge;
  logic w_act_edge;
  logic w_key_edge;
  logic w_idle_reach;
  logic w_last_tick;

  assign w_fin_edge   = finish & ~r_prev_finish;
  assign w_act_edge   = |(activity & ~r_prev_act);
  assign w_key_edge   = power_key & ~r_prev_key;
  // This tick brings idle_cnt up to IDLE_TIMEOUT.
  assign w_idle_reach = (r_idle_cnt >= (IDLE_LD - ONE));
  // <= rather than == so a zero count can never sit stuck or wrap.
  assign w_last_tick  = (r_remain <= ONE);

  always_ff @(posedge clk_s or negedge reset) begin
    if (!reset) begin
      r_state          <= StInit;
      r_prev_finish    <= 1'b0;
      r_prev_act       <= '0;
      r_prev_key       <= 1'b0;
      r_idle_cnt       <= '0;
      r_remain         <= '0;
      r_cause          <= CAUSE_NONE;
      r_off_cause      <= CAUSE_NONE;
      r_power_on       <= 1'b0;
      r_warn_led       <= 1'b0;
      r_finish_pending <= 1'b0;
    end else begin
      r_prev_finish <= finish;
      r_prev_act    <= activity;
      r_prev_key    <= power_key;

      case (r_state)
        // Edges seen in this cycle are deliberately dropped; prev registers still load.
        StInit: begin
          r_state    <= StOn;
          r_power_on <= 1'b1;
          r_idle_cnt <= '0;
        end

        StOn: begin
          if (w_fin_edge) begin
            r_state          <= StFinWait;
            r_remain         <= FIN_LD;
            r_finish_pending <= 1'b1;
            r_idle_cnt       <= '0;
          end else if (w_act_edge || running) begin
            r_idle_cnt <= '0;
          end else if (tick_en) begin
            if (w_idle_reach) begin
              r_state    <= StWarn;
              r_remain   <= WARN_LD;
              r_warn_led <= 1'b1;
              r_cause    <= CAUSE_IDLE;
              r_idle_cnt <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + ONE;
            end
          end
        end

        StFinWait: begin
          if (w_act_edge) begin
            r_state          <= StOn;
            r_finish_pending <= 1'b0;
            r_idle_cnt       <= '0;
            r_remain         <= '0;
          end else if (tick_en) begin
            if (w_last_tick) begin
              r_state    <= StWarn;
              r_remain   <= WARN_LD;
              r_warn_led <= 1'b1;
              r_cause    <= CAUSE_FINISH;
            end else begin
              r_remain <= r_remain - ONE;
            end
          end
        end

        StWarn: begin
          if (w_act_edge) begin
            r_state          <= StOn;
            r_warn_led       <= 1'b0;
            r_finish_pending <= 1'b0;
            r_remain         <= '0;
            r_cause          <= CAUSE_NONE;
            r_idle_cnt       <= '0;
          end else if (tick_en) begin
            if (w_last_tick) begin
              r_state          <= StOff;
              r_power_on       <= 1'b0;
              r_off_cause      <= r_cause;
              r_finish_pending <= 1'b0;
              r_warn_led       <= 1'b0;
              r_remain         <= '0;
              r_cause          <= CAUSE_NONE;
            end else begin
              r_remain   <= r_remain - ONE;
              r_warn_led <= ~r_warn_led;
            end
          end
        end

        StOff: begin
          if (w_key_edge) begin
            r_state     <= StOn;
            r_power_on  <= 1'b1;
            r_off_cause <= CAUSE_NONE;
            r_idle_cnt  <= '0;
          end
        end

        default: begin
          r_state <= StInit;
        end
      endcase
    end
  end

  assign power_on       = r_power_on;
  assign power_led      = reset & r_power_on;
  assign warn_led       = r_warn_led;
  assign finish_pending = r_finish_pending;
  assign remain         = r_remain;
  assign off_cause      = r_off_cause;

endmodule
